// File: rtl/ksa_wide_addsub_seq.sv
// Multi-cycle WORDS*16-bit add/subtract engine: one 16-bit Kogge-Stone adder is
// reused once per slice, LS slice first, with the inter-slice carry held in a register.

module ksa16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);
    logic [15:0] half;
    logic [15:0] carry;

    // Four prefix levels (span 1,2,4,8); cin is folded into bit 0's generate.
    always_comb begin
        logic [15:0] g, p, gn, pn;
        half = a ^ b;
        g    = a & b;
        g[0] = g[0] | (half[0] & cin);
        p    = half;
        for (int l = 0; l < 4; l++) begin
            gn = g;
            pn = p;
            for (int i = (1 << l); i < 16; i++) begin
                gn[i] = g[i] | (p[i] & g[i - (1 << l)]);
                pn[i] = p[i] & p[i - (1 << l)];
            end
            g = gn;
            p = pn;
        end
        carry = g;
    end

    assign sum  = half ^ {carry[14:0], cin};
    assign cout = carry[15];
endmodule

module ksa_wide_addsub_seq #(
    parameter int WORDS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [16*WORDS-1:0] in_a,
    input  logic [16*WORDS-1:0] in_b,
    input  logic                in_cin,
    input  logic                in_op,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [16*WORDS-1:0] out_sum,
    output logic                out_cout,
    output logic                out_ovf,
    output logic                busy
);
    localparam int W  = 16 * WORDS;
    localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [W-1:0]    result_d;
    logic            carry_q;
    logic [CW-1:0]   cnt_q;
    logic [15:0]     slice_sum;
    logic            slice_cout;
    logic            accept;
    logic            last;

    // Handshake: a transfer happens on a rising edge where valid & ready are both
    // high; in_ready is high only in IDLE, out_valid only in DONE, and neither
    // depends combinationally on the other side's valid/ready.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign accept    = in_valid & in_ready;
    assign last      = (cnt_q == CW'(WORDS - 1));

    ksa16 u_adder (
        .a    (a_q[16*cnt_q +: 16]),
        .b    (b_q[16*cnt_q +: 16]),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    // Finished slices overwrite the consumed A slices, so out_sum stays
    // untouched until the whole result is ready.
    always_comb begin
        result_d                 = a_q;
        result_d[16*cnt_q +: 16] = slice_sum;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = RUN;
            RUN:     if (last)      state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            out_sum  <= '0;
            out_cout <= 1'b0;
            out_ovf  <= 1'b0;
        end else if (accept) begin
            a_q     <= in_a;
            b_q     <= in_op ? ~in_b : in_b;
            carry_q <= in_op ? ~in_cin : in_cin;
            cnt_q   <= '0;
        end else if (state_q == RUN) begin
            a_q     <= result_d;
            carry_q <= slice_cout;
            cnt_q   <= cnt_q + 1'b1;
            if (last) begin
                out_sum  <= result_d;
                out_cout <= slice_cout;
                out_ovf  <= (a_q[W-1] == b_q[W-1]) & (slice_sum[15] != a_q[W-1]);
            end
        end
    end
endmodule

// File: tb/tb_ksa_wide_addsub_seq.sv
// Bench for ksa_wide_addsub_seq (WORDS=4): directed table, backpressure and
// mid-op reset sequences, then random ops scored against an arithmetic model.

module tb_ksa_wide_addsub_seq;
    localparam int WORDS = 4;
    localparam int W     = 16 * WORDS;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;
    logic         in_op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         out_ovf;
    logic         busy;

    int checks = 0;
    int errors = 0;
    logic [W+1:0] exp_q[$];

    ksa_wide_addsub_seq #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         op;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    // Returns {ovf, cout, sum} from plain wide arithmetic on the operands.
    function automatic logic [W+1:0] model(logic [W-1:0] a, logic [W-1:0] b, logic cin, logic op);
        logic [W:0]   wide;
        logic [W-1:0] s;
        logic         c, v;
        if (!op) begin
            wide = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
            s    = wide[W-1:0];
            c    = wide[W];
            v    = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
        end else begin
            s = a - b - W'(cin);
            c = ({1'b0, a} >= ({1'b0, b} + (W+1)'(cin)));
            v = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]);
        end
        return {v, c, s};
    endfunction

    task automatic check(string name, logic [W-1:0] act, logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] rand_operand();
        case ($urandom_range(0, 5))
            0:       return '1;
            1:       return '0;
            2:       return {1'b1, {(W-1){1'b0}}};
            3:       return {1'b0, {(W-1){1'b1}}};
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic send(logic [W-1:0] a, logic [W-1:0] b, logic cin, logic op);
        int budget = 0;
        in_a = a; in_b = b; in_cin = cin; in_op = op; in_valid = 1'b1;
        while (!in_ready && budget < 50) begin
            @(posedge clk); #1;
            budget++;
        end
        if (!in_ready) check("accept_wait", {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Counts edges from the accepting edge until out_valid; noisy mode wiggles
    // out_ready and the command inputs while the op is in flight.
    task automatic wait_result(input bit noisy, output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            if (noisy) begin
                out_ready = 1'($urandom_range(0, 1));
                in_valid  = 1'($urandom_range(0, 1));
                in_a      = {$urandom, $urandom};
                in_b      = {$urandom, $urandom};
                in_op     = 1'($urandom_range(0, 1));
            end
            @(posedge clk); #1;
            lat++;
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
    endtask

    task automatic drain(int stall);
        logic [W+1:0] snap;
        snap = {out_ovf, out_cout, out_sum};
        out_ready = 1'b0;
        repeat (stall) begin
            @(posedge clk); #1;
            check("stall_stable", W'({out_ovf, out_cout, out_sum} ^ snap), '0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("handshake_valid_low", {63'd0, out_valid}, 64'd0);
    endtask

    task automatic do_op(string name, logic [W-1:0] a, logic [W-1:0] b, logic cin, logic op,
                         int stall, bit noisy);
        int           lat;
        logic [W+1:0] e;
        exp_q.push_back(model(a, b, cin, op));
        send(a, b, cin, op);
        wait_result(noisy, lat);
        check({name, "_latency"}, W'(lat), W'(WORDS));
        e = exp_q.pop_front();
        check({name, "_sum"}, out_sum, e[W-1:0]);
        check({name, "_cout"}, {63'd0, out_cout}, {63'd0, e[W]});
        check({name, "_ovf"}, {63'd0, out_ovf}, {63'd0, e[W+1]});
        drain(stall);
        check({name, "_retain"}, out_sum, e[W-1:0]);
    endtask

    initial begin
        vec_t         vecs[6];
        int           lat;
        logic [W+1:0] snap;
        logic [W+1:0] e;
        logic [W-1:0] qa, qb;

        vecs[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0};
        vecs[1] = '{64'h0000_0000_FFFF_FFFF, 64'd1, 1'b1, 1'b0, 64'h0000_0001_0000_0001, 1'b0, 1'b0};
        vecs[2] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
        vecs[3] = '{64'h0, 64'd1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
        vecs[4] = '{64'd5, 64'd3, 1'b1, 1'b1, 64'd1, 1'b1, 1'b0};
        vecs[5] = '{64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_cin = 1'b0; in_op = 1'b0;
        #1;
        check("reset_out_valid", {63'd0, out_valid}, 64'd0);
        check("reset_in_ready", {63'd0, in_ready}, 64'd1);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_out_sum", out_sum, 64'd0);
        check("reset_flags", {62'd0, out_cout, out_ovf}, 64'd0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            send(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].op);
            check("table_busy", {63'd0, busy}, 64'd1);
            wait_result(1'b0, lat);
            check("table_latency", W'(lat), W'(WORDS));
            check("table_sum", out_sum, vecs[i].sum);
            check("table_cout", {63'd0, out_cout}, {63'd0, vecs[i].cout});
            check("table_ovf", {63'd0, out_ovf}, {63'd0, vecs[i].ovf});
            drain(i % 3);
        end

        // Backpressure with a command waiting at the input the whole time.
        send(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0, 1'b0);
        wait_result(1'b0, lat);
        check("bp_latency", W'(lat), W'(WORDS));
        snap = {out_ovf, out_cout, out_sum};
        check("bp_sum", out_sum, 64'h2345_6789_ABCD_F001);
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_a = {$urandom, $urandom}; in_b = {$urandom, $urandom};
            in_op = 1'($urandom_range(0, 1)); in_cin = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            check("bp_stable", W'({out_ovf, out_cout, out_sum} ^ snap), '0);
            check("bp_in_ready", {62'd0, in_ready, out_valid}, 64'd1);
        end
        qa = 64'hDEAD_BEEF_0000_FFFF; qb = 64'h0000_0001_FFFF_0001;
        in_a = qa; in_b = qb; in_cin = 1'b1; in_op = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_release", {62'd0, out_valid, in_ready}, 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_queued_accept", {62'd0, busy, in_ready}, 64'd2);
        wait_result(1'b0, lat);
        check("bp_queued_latency", W'(lat), W'(WORDS));
        e = model(qa, qb, 1'b1, 1'b1);
        check("bp_queued_sum", out_sum, e[W-1:0]);
        check("bp_queued_flags", {62'd0, out_ovf, out_cout}, {62'd0, e[W+1], e[W]});
        drain(0);

        // Reset while slice 2 is being computed.
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        check("midrst_busy", {63'd0, busy}, 64'd0);
        check("midrst_out_sum", out_sum, 64'd0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        check("midrst_in_ready", {63'd0, in_ready}, 64'd1);
        check("midrst_no_result", {63'd0, out_valid}, 64'd0);
        do_op("post_reset", 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b1, 1'b0, 1, 1'b0);

        for (int n = 0; n < 2000; n++) begin
            do_op("rand", rand_operand(), rand_operand(), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
